fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/ack plus the decode-side valid/ready stream.
// Latency: wiring only. Backpressure: instr_ready from decode stalls delivery, imem_ack from memory stalls fetch.
// The master modport is the fetch unit; the slave modport is memory plus decode.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instr, opcode, pc_out, instr_valid,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr, opcode, pc_out, instr_valid,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: requests imem at pc, captures the word, and presents it to decode with its pc.
// Latency: ack in cycle N -> instr_valid from N+1; at least 2 cycles per instruction. Backpressure: holds the instruction while instr_ready=0.
// Optional FETCH_COUNT_EN adds a 32-bit fetch_count of accepted instructions.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    fetch_if.master     bus
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        instr_valid_q, instr_valid_d;

    logic [31:0] redirect_tgt;
    logic        unused_redirect_bits;

    assign redirect_tgt         = {bus.redirect_pc[31:2], 2'b00};
    assign unused_redirect_bits = ^bus.redirect_pc[1:0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        imem_addr_d   = imem_addr_q;
        imem_req_d    = imem_req_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        instr_valid_d = instr_valid_q;

        // A redirect wins over everything, so a coincident ack is simply dropped.
        if (bus.redirect) begin
            state_d       = S_FETCH;
            pc_d          = redirect_tgt;
            imem_addr_d   = redirect_tgt;
            imem_req_d    = 1'b1;
            instr_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    // req is low only in the first cycle out of reset; an ack then is not ours.
                    imem_req_d = 1'b1;
                    if (imem_req_q && bus.imem_ack) begin
                        instr_d       = bus.imem_rdata;
                        pc_out_d      = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + 32'd4;
                        imem_req_d    = 1'b0;
                        state_d       = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.instr_ready) begin
                        instr_valid_d = 1'b0;
                        imem_addr_d   = pc_q;
                        imem_req_d    = 1'b1;
                        state_d       = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            imem_addr_q   <= RESET_PC;
            imem_req_q    <= 1'b0;
            instr_q       <= 32'h0;
            pc_out_q      <= 32'h0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_addr_q   <= imem_addr_d;
            imem_req_q    <= imem_req_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = imem_addr_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[31:26];
    assign bus.pc_out      = pc_out_q;
    assign bus.instr_valid = instr_valid_q;

`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (instr_valid_q && bus.instr_ready) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_count_q <= 32'h0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory/decode driver with a transaction-level expected-fetch model feeding a scoreboard.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_if bus ();
    fetch_if wbus ();

`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
    logic [31:0] w_fetch_count;
`endif

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk         (clk),
        .rst         (rst),
        .bus         (wbus)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count (w_fetch_count)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc = 32'h0;
    int          model_cnt = 0;
    bit          prev_iv = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One bus cycle on the main DUT; called and returning at a falling edge.
    task automatic step(input bit ack, input logic [31:0] rdata, input bit rdy,
                        input bit redir, input logic [31:0] rpc);
        bit req_now;
        bit valid_now;
        req_now   = bus.imem_req;
        valid_now = bus.instr_valid;
        if (req_now) check32("fetch_addr", bus.imem_addr, model_pc);
        bus.imem_ack    = ack;
        bus.imem_rdata  = rdata;
        bus.instr_ready = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        @(posedge clk);
        if (valid_now && rdy) model_cnt++;
        if (redir) begin
            model_pc = {rpc[31:2], 2'b00};
        end else if (ack && req_now) begin
            exp_q.push_back('{pc: model_pc, word: rdata});
            model_pc = model_pc + 32'd4;
        end
        @(negedge clk);
    endtask

    // Reset with random ack/redirect noise, which must all be ignored.
    task automatic do_reset(input int n);
        rst = 1'b0;
        bus.imem_ack    = 1'($urandom_range(0, 1));
        bus.imem_rdata  = $urandom;
        bus.redirect    = 1'($urandom_range(0, 1));
        bus.redirect_pc = $urandom;
        bus.instr_ready = 1'($urandom_range(0, 1));
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst             = 1'b1;
        bus.imem_ack    = 1'b0;
        bus.redirect    = 1'b0;
        bus.instr_ready = 1'b0;
        model_pc        = 32'h0;
        model_cnt       = 0;
        exp_q.delete();
    endtask

    // Scoreboard monitor: a rising instr_valid is a new delivery; while high it must stay stable.
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (bus.instr_valid && bus.imem_req) begin
                errors++;
                $display("FAIL req_valid_exclusive: req=1 valid=1, expected not both");
            end
            if (bus.instr_valid && !prev_iv) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc %h word %h, expected none", bus.pc_out, bus.instr);
                end else begin
                    cur = exp_q.pop_front();
                    check32("sb_instr", bus.instr, cur.word);
                    check32("sb_pc_out", bus.pc_out, cur.pc);
                    check32("sb_opcode", {26'h0, bus.opcode}, {26'h0, cur.word[31:26]});
                end
            end else if (bus.instr_valid && prev_iv) begin
                check32("hold_instr", bus.instr, cur.word);
                check32("hold_pc_out", bus.pc_out, cur.pc);
            end
        end
        prev_iv = bus.instr_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ack;
        bit          redir;
        logic [31:0] rpc;

        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.instr_ready = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
        wbus.imem_ack = 1'b0; wbus.imem_rdata = 32'h0; wbus.instr_ready = 1'b0;
        wbus.redirect = 1'b0; wbus.redirect_pc = 32'h0;

        // Reset state, then first request.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("rst_req", {31'h0, bus.imem_req}, 32'h0);
        check32("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
        check32("rst_instr", bus.instr, 32'h0);
        check32("rst_pc_out", bus.pc_out, 32'h0);
        check32("rst_addr", bus.imem_addr, 32'h0);
        rst = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check32("post_rst_req", {31'h0, bus.imem_req}, 32'h1);
        check32("post_rst_addr", bus.imem_addr, 32'h0);
        check32("post_rst_opcode", {26'h0, bus.opcode}, 32'h0);

        // Basic fetch of addi.
        step(1'b1, 32'h2008_0005, 1'b0, 1'b0, 32'h0);
        check32("fetch_valid", {31'h0, bus.instr_valid}, 32'h1);
        check32("fetch_opcode", {26'h0, bus.opcode}, 32'h08);
        check32("fetch_pc_out", bus.pc_out, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check32("next_addr", bus.imem_addr, 32'h4);
        check32("next_req", {31'h0, bus.imem_req}, 32'h1);

        // Backpressure with lw held for 5 cycles.
        step(1'b1, 32'h8C09_0000, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check32("bp_req", {31'h0, bus.imem_req}, 32'h0);
            check32("bp_opcode", {26'h0, bus.opcode}, 32'h23);
            check32("bp_pc_out", bus.pc_out, 32'h4);
            step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check32("race_pre_addr", bus.imem_addr, 32'h8);

        // Redirect racing an ack: ack dropped, target aligned.
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h43);
        check32("race_valid", {31'h0, bus.instr_valid}, 32'h0);
        check32("race_addr", bus.imem_addr, 32'h40);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check32("race_valid2", {31'h0, bus.instr_valid}, 32'h0);

        // Randomized traffic with redirects, near-top targets and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                ack   = bus.imem_req && ($urandom_range(0, 1) == 1);
                redir = ($urandom_range(0, 11) == 0);
                rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                    : 32'($urandom);
                step(ack, $urandom, 1'($urandom_range(0, 1)), redir, rpc);
            end
        end
`ifdef FETCH_COUNT_EN
        check32("rand_fetch_count", fetch_count, 32'(model_cnt));
`endif

        // Wrap from the top of the address space on the second instance.
        do_reset(2);
        @(posedge clk); @(negedge clk);
        check32("wrap_req", {31'h0, wbus.imem_req}, 32'h1);
        check32("wrap_addr0", wbus.imem_addr, 32'hFFFF_FFFC);
        wbus.imem_ack = 1'b1; wbus.imem_rdata = 32'h1000_0003;
        @(posedge clk); @(negedge clk);
        wbus.imem_ack = 1'b0;
        check32("wrap_valid", {31'h0, wbus.instr_valid}, 32'h1);
        check32("wrap_opcode", {26'h0, wbus.opcode}, 32'h04);
        check32("wrap_pc_out", wbus.pc_out, 32'hFFFF_FFFC);
        wbus.instr_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        wbus.instr_ready = 1'b0;
        check32("wrap_next_addr", wbus.imem_addr, 32'h0);
        check32("wrap_next_req", {31'h0, wbus.imem_req}, 32'h1);

`ifdef FETCH_COUNT_EN
        do_reset(2);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0000_0020 + 32'(i), 1'b0, 1'b0, 32'h0);
            step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        end
        check32("count_three", fetch_count, 32'd3);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check32("count_reset", fetch_count, 32'd0);
        rst = 1'b1;
`endif

        check32("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
